pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Pipeline control block that consumes the hazard/forwarding unit's stall request and ID-stage redirect indications, and drives the PC and pipeline-register write enables and flushes. It sits between the forwarding unit and the IF/ID and ID/EX pipeline registers. It tracks stall episodes with a small FSM, enforces a stall watchdog, and keeps saturating performance counters for stall cycles and flushes.

## Interface
Parameters:
- MAX_STALL, 8: consecutive stall cycles that trip the watchdog (legal range 2..255).
- CW, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall_req  in  1  combined stall (load-use or load-branch/jr) from the forwarding unit; same-cycle.
- redirect  in  1  taken branch or jump resolved in ID this cycle.
- clr_cnt  in  1  synchronous clear of both performance counters.
- PCWrite  out  1  PC register write enable.
- IFID_Write  out  1  IF/ID register write enable.
- IFID_Flush  out  1  zero the IF/ID register (squash the wrong-path fetch).
- IDEX_Flush  out  1  insert a bubble into ID/EX.
- stall_active  out  1  registered: state is STALLED.
- timeout  out  1  registered, sticky watchdog error.
- stall_cnt  out  CW  saturating count of stalled cycles.
- flush_cnt  out  CW  saturating count of accepted redirects.

## Operation
- FSM states: FILL, RUN, STALLED, TIMEOUT. Reset state is FILL.
- FILL lasts exactly one cycle, then goes to RUN unconditionally. In FILL: PCWrite=1, IFID_Write=1, IDEX_Flush=1 (first ID/EX contents are junk), IFID_Flush=0. stall_req and redirect are ignored.
- RUN and STALLED drive outputs combinationally from the inputs:
  - PCWrite = IFID_Write = !stall_req.
  - IDEX_Flush = stall_req.
  - IFID_Flush = redirect & !stall_req.
- Priority: stall beats redirect. While stalled, the branch operands are stale, so the redirect is suppressed and re-evaluated next cycle.
- Transitions:
  - RUN → STALLED when stall_req=1.
  - STALLED → RUN when stall_req=0.
  - STALLED → TIMEOUT when stall_req=1 and run_len==MAX_STALL-1.
- run_len is an internal 8-bit counter.
  - Cleared on entry to RUN and while in RUN.
  - Increments on each STALLED cycle with stall_req=1.
  - Run length counts the first stall cycle, taken in RUN, as 1. A MAX_STALL-cycle continuous stall therefore trips on its MAX_STALL-th cycle.
- TIMEOUT is absorbing until reset. Outputs: PCWrite=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0, timeout=1.
- stall_cnt:
  - Increments on every cycle where the block drives PCWrite=0 due to stall_req in RUN or STALLED. TIMEOUT cycles do not count.
  - Saturates at 2^CW-1.
- flush_cnt: increments on every cycle with IFID_Flush=1; saturates at 2^CW-1.
- clr_cnt=1 zeroes both counters on the next edge and takes priority over an increment in the same cycle. It does not affect FSM, run_len or timeout.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=FILL, run_len=0, stall_cnt=0, flush_cnt=0, stall_active=0, timeout=0.
  - Combinational outputs follow FILL: PCWrite=1, IFID_Write=1, IDEX_Flush=1, IFID_Flush=0.
- Latency:
  - Enables and flushes respond in the same cycle as stall_req/redirect (zero latency).
  - stall_active, timeout and counters update one cycle later.
- Reset asserted mid-stall or in TIMEOUT: immediate return to FILL with all registers cleared.
- Back-to-back stalls with a single 0 cycle between them: run_len restarts at 0; no timeout carry-over.
- Counter at saturation with an increment and no clr_cnt: holds at 2^CW-1.

## Test plan
- Reset release: first cycle shows IDEX_Flush=1 and PCWrite=1; second cycle RUN with stall_req=0 shows all flushes 0, PCWrite=1, stall_cnt=0.
- Single load-use stall: stall_req=1 for 1 cycle → PCWrite=0, IDEX_Flush=1 that cycle; next cycle stall_active=1, stall_cnt=1; then back to RUN with stall_active=0.
- Stall and redirect together: stall_req=1 and redirect=1 for 2 cycles, then redirect=1 alone → IFID_Flush=0 for 2 cycles, then 1; final values stall_cnt=2, flush_cnt=1.
- Watchdog with MAX_STALL=8: stall_req held high → cycles 1–7 stalled; on cycle 8 state goes to TIMEOUT; timeout=1 from cycle 9. Dropping stall_req leaves PCWrite=0 and IDEX_Flush=1 until rst_n pulses.
- Watchdog non-trip: 7 stall cycles, 1 free cycle, 7 stall cycles → timeout stays 0; stall_cnt=14.
- Saturation and clear with CW=4: 20 redirects → flush_cnt=15. Then clr_cnt=1 together with redirect=1 → flush_cnt=0 on the next cycle.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the hazard/forwarding unit and the pipeline stall controller.
// master drives the hazard indications; slave is the stall controller itself.
interface pipeline_stall_ctrl_if #(
  parameter int CW = 16
);
  logic          stall_req;
  logic          redirect;
  logic          clr_cnt;
  logic          PCWrite;
  logic          IFID_Write;
  logic          IFID_Flush;
  logic          IDEX_Flush;
  logic          stall_active;
  logic          timeout;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  modport master (
    output stall_req, redirect, clr_cnt,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush,
    input  stall_active, timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall_req, redirect, clr_cnt,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush,
    output stall_active, timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: PC and IF/ID write enables, flushes, stall watchdog
// and saturating stall/flush performance counters.
module pipeline_stall_ctrl #(
  parameter int MAX_STALL = 8,
  parameter int CW        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_stall_ctrl_if.slave bus
);
  typedef enum logic [1:0] {FILL, RUN, STALLED, TIMEOUT} state_t;

  localparam logic [7:0]    TRIP    = 8'(MAX_STALL - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state_reg;
  logic [7:0]    run_len_reg;
  logic          stall_active_reg;
  logic          timeout_reg;
  logic [CW-1:0] stall_cnt_reg;
  logic [CW-1:0] flush_cnt_reg;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_flush;
  logic stall_inc;

  // Stall beats redirect: with a stall pending the branch operands are stale.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b1;
    stall_inc  = 1'b0;
    case (state_reg)
      FILL: begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b1;
      end
      RUN, STALLED: begin
        pc_write   = !bus.stall_req;
        ifid_write = !bus.stall_req;
        ifid_flush = bus.redirect && !bus.stall_req;
        idex_flush = bus.stall_req;
        stall_inc  = bus.stall_req;
      end
      TIMEOUT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b1;
      end
      default: begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= FILL;
      run_len_reg      <= 8'd0;
      stall_active_reg <= 1'b0;
      timeout_reg      <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          state_reg   <= RUN;
          run_len_reg <= 8'd0;
        end
        RUN: begin
          // The stall cycle taken in RUN is the first of the episode.
          if (bus.stall_req) begin
            state_reg        <= STALLED;
            stall_active_reg <= 1'b1;
            run_len_reg      <= 8'd1;
          end else begin
            run_len_reg <= 8'd0;
          end
        end
        STALLED: begin
          if (!bus.stall_req) begin
            state_reg        <= RUN;
            stall_active_reg <= 1'b0;
            run_len_reg      <= 8'd0;
          end else if (run_len_reg == TRIP) begin
            state_reg        <= TIMEOUT;
            stall_active_reg <= 1'b0;
            timeout_reg      <= 1'b1;
          end else begin
            run_len_reg <= run_len_reg + 8'd1;
          end
        end
        TIMEOUT: begin
          state_reg   <= TIMEOUT;
          timeout_reg <= 1'b1;
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (bus.clr_cnt) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_inc && stall_cnt_reg != CNT_MAX) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (ifid_flush && flush_cnt_reg != CNT_MAX) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign bus.PCWrite      = pc_write;
  assign bus.IFID_Write   = ifid_write;
  assign bus.IFID_Flush   = ifid_flush;
  assign bus.IDEX_Flush   = idex_flush;
  assign bus.stall_active = stall_active_reg;
  assign bus.timeout      = timeout_reg;
  assign bus.stall_cnt    = stall_cnt_reg;
  assign bus.flush_cnt    = flush_cnt_reg;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl; a CW=4 copy covers counter saturation.
module tb_pipeline_stall_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pipeline_stall_ctrl_if #(.CW(16)) bus16 ();
  pipeline_stall_ctrl_if #(.CW(4))  bus4 ();

  pipeline_stall_ctrl #(.MAX_STALL(8), .CW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  pipeline_stall_ctrl #(.MAX_STALL(8), .CW(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic c);
    bus16.stall_req = s;
    bus16.redirect  = r;
    bus16.clr_cnt   = c;
    bus4.stall_req  = s;
    bus4.redirect   = r;
    bus4.clr_cnt    = c;
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUTs in the FILL cycle with idle inputs.
  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;

    // Reset release and FILL behaviour
    do_reset();
    check_eq("rst_stall_cnt", bus16.stall_cnt, 0);
    check_eq("rst_timeout", bus16.timeout, 0);
    drive(1'b1, 1'b1, 1'b0);
    check_eq("fill_pcwrite", bus16.PCWrite, 1);
    check_eq("fill_idex_flush", bus16.IDEX_Flush, 1);
    check_eq("fill_ifid_flush", bus16.IFID_Flush, 0);
    cycle();
    drive(1'b0, 1'b0, 1'b0);
    check_eq("run_pcwrite", bus16.PCWrite, 1);
    check_eq("run_idex_flush", bus16.IDEX_Flush, 0);
    check_eq("run_ifid_flush", bus16.IFID_Flush, 0);
    check_eq("run_stall_cnt", bus16.stall_cnt, 0);
    check_eq("run_stall_active", bus16.stall_active, 0);

    // Single load-use stall
    drive(1'b1, 1'b0, 1'b0);
    check_eq("ld_pcwrite", bus16.PCWrite, 0);
    check_eq("ld_ifid_write", bus16.IFID_Write, 0);
    check_eq("ld_idex_flush", bus16.IDEX_Flush, 1);
    cycle();
    drive(1'b0, 1'b0, 1'b0);
    check_eq("ld_stall_active", bus16.stall_active, 1);
    check_eq("ld_stall_cnt", bus16.stall_cnt, 1);
    check_eq("ld_release_pcwrite", bus16.PCWrite, 1);
    cycle();
    check_eq("ld_back_to_run", bus16.stall_active, 0);

    // Stall and redirect together: stall wins
    do_reset();
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      check_eq("sr_ifid_flush_suppressed", bus16.IFID_Flush, 0);
      cycle();
    end
    drive(1'b0, 1'b1, 1'b0);
    check_eq("sr_ifid_flush_taken", bus16.IFID_Flush, 1);
    cycle();
    drive(1'b0, 1'b0, 1'b0);
    check_eq("sr_stall_cnt", bus16.stall_cnt, 2);
    check_eq("sr_flush_cnt", bus16.flush_cnt, 1);

    // Watchdog trips on the 8th continuous stall cycle
    do_reset();
    cycle();
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      check_eq($sformatf("wd_pcwrite_c%0d", i), bus16.PCWrite, 0);
      cycle();
      if (i <= 7) begin
        check_eq($sformatf("wd_active_c%0d", i), bus16.stall_active, 1);
        check_eq($sformatf("wd_timeout_c%0d", i), bus16.timeout, 0);
      end
    end
    check_eq("wd_timeout", bus16.timeout, 1);
    check_eq("wd_active_cleared", bus16.stall_active, 0);
    check_eq("wd_stall_cnt", bus16.stall_cnt, 8);
    drive(1'b0, 1'b1, 1'b0);
    check_eq("wd_hold_pcwrite", bus16.PCWrite, 0);
    check_eq("wd_hold_ifid_write", bus16.IFID_Write, 0);
    check_eq("wd_hold_idex_flush", bus16.IDEX_Flush, 1);
    check_eq("wd_hold_ifid_flush", bus16.IFID_Flush, 0);
    cycle();
    cycle();
    check_eq("wd_sticky", bus16.timeout, 1);
    check_eq("wd_stall_cnt_frozen", bus16.stall_cnt, 8);
    check_eq("wd_flush_cnt_frozen", bus16.flush_cnt, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("wd_async_rst_timeout", bus16.timeout, 0);
    check_eq("wd_async_rst_pcwrite", bus16.PCWrite, 1);
    check_eq("wd_async_rst_cnt", bus16.stall_cnt, 0);

    // Watchdog non-trip: 7 stalls, 1 free, 7 stalls
    do_reset();
    cycle();
    for (int i = 0; i < 15; i++) begin
      drive((i == 7) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0);
    check_eq("nt_timeout", bus16.timeout, 0);
    check_eq("nt_stall_cnt", bus16.stall_cnt, 14);
    check_eq("nt_stall_cnt_cw4", bus4.stall_cnt, 14);
    cycle();
    check_eq("nt_timeout_after", bus16.timeout, 0);
    check_eq("nt_pcwrite", bus16.PCWrite, 1);

    // Saturation on CW=4, then clear beats increment
    do_reset();
    cycle();
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle();
    check_eq("sat_flush_cnt_cw4", bus4.flush_cnt, 15);
    check_eq("sat_flush_cnt_cw16", bus16.flush_cnt, 20);
    drive(1'b0, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 1'b0);
    check_eq("clr_flush_cnt_cw4", bus4.flush_cnt, 0);
    check_eq("clr_flush_cnt_cw16", bus16.flush_cnt, 0);
    check_eq("clr_no_fsm_effect", bus16.PCWrite, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
